// File: rtl/icache_fetch_pkg.sv
// rtl/icache_fetch_pkg.sv - shared constants and FSM state codes for the fetch stage
package icache_fetch_pkg;

  localparam logic        ResetEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ICF_IDLE   = 2'd0,
    ICF_REFILL = 2'd1,
    ICF_RESP   = 2'd2
  } icf_state_e;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/data storage, one comb read port, one line write port
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int SET_BITS = 7,
  parameter int OFF_BITS = 1,
  parameter int TAG_W    = 22,
  parameter int INST_W   = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   inv_i,
  input  logic [SET_BITS-1:0]                    rd_idx_i,
  output logic                                   rd_valid_o,
  output logic [TAG_W-1:0]                       rd_tag_o,
  output logic [(1<<OFF_BITS)-1:0][INST_W-1:0]   rd_line_o,
  input  logic                                   wr_en_i,
  input  logic [SET_BITS-1:0]                    wr_idx_i,
  input  logic [TAG_W-1:0]                       wr_tag_i,
  input  logic [(1<<OFF_BITS)-1:0][INST_W-1:0]   wr_line_i
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << OFF_BITS;

  logic [SETS-1:0]              valid_q;
  logic [TAG_W-1:0]             tag_q  [SETS];
  logic [WORDS-1:0][INST_W-1:0] data_q [SETS];

  // An invalidate landing on the same cycle as a line write leaves that line invalid.
  always_ff @(posedge clk) begin
    if (rst == ResetEnable || inv_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - fetch stage with direct-mapped multi-word-line icache and word-wise line refill
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INST_W   = 32,
  parameter int SET_BITS = 7,
  parameter int OFF_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              inv_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_valid_o,
  output logic              stall_req_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [INST_W-1:0] mem_data_i,
  input  logic              mem_done_i
);

  localparam int TAG_W = ADDR_W - SET_BITS - OFF_BITS - 2;
  localparam int WORDS = 1 << OFF_BITS;

  icf_state_e                   state_q, state_d;
  logic [ADDR_W-1:0]            req_pc_q, req_pc_d;
  logic [OFF_BITS-1:0]          cnt_q, cnt_d;
  logic [WORDS-1:0][INST_W-1:0] buf_q, buf_d;
  logic                         flushed_q, flushed_d;
  logic [INST_W-1:0]            inst_q, inst_d;
  logic [ADDR_W-1:0]            pc_q, pc_d;
  logic                         valid_q, valid_d;

  logic [TAG_W-1:0]             pc_tag, req_tag, rd_tag;
  logic [SET_BITS-1:0]          pc_idx, req_idx;
  logic [OFF_BITS-1:0]          pc_off, req_off;
  logic                         rd_valid, hit, accept, refill_last;
  logic [WORDS-1:0][INST_W-1:0] rd_line, fill_line;

  assign pc_tag  = pc_i[ADDR_W-1 -: TAG_W];
  assign pc_idx  = pc_i[SET_BITS+OFF_BITS+1 -: SET_BITS];
  assign pc_off  = pc_i[OFF_BITS+1 -: OFF_BITS];
  assign req_tag = req_pc_q[ADDR_W-1 -: TAG_W];
  assign req_idx = req_pc_q[SET_BITS+OFF_BITS+1 -: SET_BITS];
  assign req_off = req_pc_q[OFF_BITS+1 -: OFF_BITS];

  assign hit         = rd_valid && (rd_tag == pc_tag);
  assign refill_last = (state_q == ICF_REFILL) && mem_done_i && (cnt_q == '1);

  // The final word bypasses the line buffer so tag, data and response go out together.
  always_comb begin
    fill_line        = buf_q;
    fill_line[cnt_q] = mem_data_i;
  end

  icache_array #(
    .SET_BITS (SET_BITS),
    .OFF_BITS (OFF_BITS),
    .TAG_W    (TAG_W),
    .INST_W   (INST_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .inv_i      (inv_i),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (refill_last),
    .wr_idx_i   (req_idx),
    .wr_tag_i   (req_tag),
    .wr_line_i  (fill_line)
  );

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    flushed_d   = flushed_q | flush_i;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    accept      = 1'b0;

    case (state_q)
      ICF_IDLE, ICF_RESP: begin
        stall_req_o = stall_i;
        accept      = pc_valid_i && !stall_i;
        if (!stall_i || flush_i) state_d = ICF_IDLE;
      end
      ICF_REFILL: begin
        stall_req_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {req_pc_q[ADDR_W-1:OFF_BITS+2], cnt_q, 2'b00};
        if (mem_done_i) begin
          buf_d = fill_line;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = (flushed_q || flush_i) ? ICF_IDLE : ICF_RESP;
        end
      end
      default: state_d = ICF_IDLE;
    endcase

    // A newly accepted pc beats flush, which only kills older work.
    if (accept) begin
      if (hit) begin
        valid_d = 1'b1;
        inst_d  = rd_line[pc_off];
        pc_d    = pc_i;
      end else begin
        valid_d   = 1'b0;
        state_d   = ICF_REFILL;
        req_pc_d  = pc_i;
        cnt_d     = '0;
        flushed_d = 1'b0;
      end
    end else if (flush_i) begin
      valid_d = 1'b0;
    end else if (refill_last && !flushed_q) begin
      valid_d = 1'b1;
      inst_d  = fill_line[req_off];
      pc_d    = req_pc_q;
    end else if (!stall_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      state_q   <= ICF_IDLE;
      req_pc_q  <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      flushed_q <= 1'b0;
      inst_q    <= INST_W'(ZeroWord);
      pc_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      flushed_q <= flushed_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - scoreboard bench for icache_fetch with a 3-cycle memory responder
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        inv_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        stall_req_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_done_i = 1'b0;

  icache_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .inv_i        (inv_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o),
    .stall_req_o  (stall_req_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .mem_done_i   (mem_done_i)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mem_words = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] inv_addr = 32'hFFFF_FFFF;
  logic [31:0] cur_addr = '0;
  bit          active = 1'b0;
  bit          lat_en = 1'b0;
  bit          lat_pending = 1'b0;
  int          wait_c = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: an instruction is consumed when valid and decode is not stalling.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && inst_valid_o && !stall_i) begin
        if (exp_pc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc %h inst %h expected none", pc_o, inst_o);
        end else begin
          check("out_pc", pc_o, exp_pc_q.pop_front());
          check("out_inst", inst_o, exp_inst_q.pop_front());
        end
      end
    end
  end

  // Memory responder: done three cycles after each word request, data = 0xDEAD0000 ^ addr.
  initial begin
    forever begin
      @(negedge clk);
      mem_done_i = 1'b0;
      inv_i      = 1'b0;
      if (lat_pending) begin
        check("resp_latency", {31'b0, inst_valid_o}, 32'd1);
        lat_pending = 1'b0;
      end
      if (rst || !mem_req_o) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active   = 1'b1;
          wait_c   = 0;
          cur_addr = mem_addr_o;
          mem_words++;
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mem_req: got %h expected none", mem_addr_o);
          end else begin
            check("mem_addr", mem_addr_o, exp_addr_q.pop_front());
          end
        end
        wait_c++;
        if (wait_c == 3) begin
          check("mem_addr_stable", mem_addr_o, cur_addr);
          mem_done_i = 1'b1;
          mem_data_i = 32'hDEAD_0000 ^ cur_addr;
          active     = 1'b0;
          if (cur_addr == inv_addr) inv_i = 1'b1;
          if (cur_addr[2]) lat_pending = lat_en;
        end
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while ((stall_req_o || mem_req_o) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got stall_req %b expected 0", stall_req_o);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input bit miss,
                       input bit flush_after);
    int words0;
    wait_ready();
    words0 = mem_words;
    if (miss) begin
      exp_addr_q.push_back({pc[31:3], 3'b000});
      exp_addr_q.push_back({pc[31:3], 3'b100});
    end
    if (!flush_after) begin
      exp_pc_q.push_back(pc);
      exp_inst_q.push_back(inst);
    end
    lat_en     = !flush_after;
    pc_i       = pc;
    pc_valid_i = 1'b1;
    @(posedge clk);
    #1;
    pc_valid_i = 1'b0;
    flush_i    = flush_after;
    if (!miss) begin
      @(negedge clk);
      check("hit_latency", {31'b0, inst_valid_o}, 32'd1);
    end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    wait_ready();
    check("miss_words", 32'(mem_words - words0), miss ? 32'd2 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_stall_req", {31'b0, stall_req_o}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    @(posedge clk);
    #1;

    fetch(32'h100, 32'hDEAD_0100, 1'b1, 1'b0);   // cold miss
    fetch(32'h104, 32'hDEAD_0104, 1'b0, 1'b0);   // same line hits
    fetch(32'h500, 32'hDEAD_0500, 1'b1, 1'b0);   // conflict evicts 0x100
    fetch(32'h100, 32'hDEAD_0100, 1'b1, 1'b0);
    fetch(32'h200, 32'hDEAD_0200, 1'b1, 1'b1);   // flushed refill still installs
    fetch(32'h204, 32'hDEAD_0204, 1'b0, 1'b0);

    // Stall on a hit: output holds and the offered pc 0x200 must not be taken.
    wait_ready();
    exp_pc_q.push_back(32'h104);
    exp_inst_q.push_back(32'hDEAD_0104);
    pc_i       = 32'h104;
    pc_valid_i = 1'b1;
    @(posedge clk);
    #1;
    stall_i = 1'b1;
    pc_i    = 32'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_inst", inst_o, 32'hDEAD_0104);
      check("stall_pc", pc_o, 32'h104);
      check("stall_valid", {31'b0, inst_valid_o}, 32'd1);
      check("stall_req", {31'b0, stall_req_o}, 32'd1);
      @(posedge clk);
      #1;
    end
    stall_i    = 1'b0;
    pc_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    inv_addr = 32'h304;                          // inv with the final done
    fetch(32'h300, 32'hDEAD_0300, 1'b1, 1'b0);
    inv_addr = 32'hFFFF_FFFF;
    fetch(32'h300, 32'hDEAD_0300, 1'b1, 1'b0);

    // Reset in the middle of a refill abandons it.
    wait_ready();
    exp_addr_q.push_back(32'h100);
    lat_en     = 1'b0;
    pc_i       = 32'h100;
    pc_valid_i = 1'b1;
    @(posedge clk);
    #1;
    pc_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_refill_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_refill_valid", {31'b0, inst_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h100, 32'hDEAD_0100, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("pending_outputs", 32'(exp_pc_q.size()), 32'd0);
    check("pending_mem_addrs", 32'(exp_addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
